// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu -- multi-cycle ALU with start/done handshake
//
// Purpose:
//   Add/sub, four bitwise ops, three shifts and (optionally) an iterative
//   unsigned shift-add multiply. Operand B is selected internally between the
//   register operand and the pre-extended immediate. Result and flags are
//   registered and held until the next completion. Single-cycle ops complete
//   one edge after start is accepted; MUL completes WIDTH edges after.
//
// Build option:
//   SEQ_ALU_MUL_EN  when defined, the MUL state, iteration counter,
//                   2*WIDTH accumulator and resultHi logic are compiled in.
//                   When undefined, op 9 behaves like any undefined op and
//                   busy / resultHi are tied to 0.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   SHW    shift-amount width, derived from WIDTH
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         synchronous, active-high
//   start         request, sampled only while idle
//   op            0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOR 6 SLL 7 SRL 8 SRA 9 MUL
//   rs_           operand A
//   rt_           operand B (register)
//   imm           operand B (immediate)
//   ALUimm        1: B = imm, 0: B = rt_
//   result        registered result (low word for MUL)
//   resultHi      MUL high word, 0 after any other completion
//   zFlag, carryFlag, signFlag, overflowFlag   registered flags
//   busy          high while a MUL is iterating
//   done          one-cycle completion pulse
// ============================================================================
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_,
    input  logic [WIDTH-1:0] rt_,
    input  logic [WIDTH-1:0] imm,
    input  logic             ALUimm,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zFlag,
    output logic             carryFlag,
    output logic             signFlag,
    output logic             overflowFlag,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    // ------------------------------------------------------------------------
    // Operand selection and single-cycle datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] opb;
    logic [SHW-1:0]   shamt;

    assign opb   = ALUimm ? imm : rt_;
    assign shamt = opb[SHW-1:0];   // upper bits of B deliberately ignored

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;

    assign sum_add = {1'b0, rs_} + {1'b0, opb};
    assign sum_sub = {1'b0, rs_} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};

    // Shifts are done on a vector one bit wider than the operand so the last
    // bit shifted out lands in the extra position. With amount 0 that extra
    // bit is the zero pad, which gives carry=0 for free.
    logic [WIDTH:0] sll_x;
    logic [WIDTH:0] srl_x;
    logic [WIDTH:0] sra_x;

    assign sll_x = {1'b0, rs_} << shamt;
    assign srl_x = {rs_, 1'b0} >> shamt;
    assign sra_x = $signed({rs_, 1'b0}) >>> shamt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_z;
    logic             alu_s;
    logic             alu_known;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_known = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (rs_[WIDTH-1] == opb[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != rs_[WIDTH-1]);
            end
            OP_SUB: begin
                // carry here means "no borrow"
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (rs_[WIDTH-1] != opb[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != rs_[WIDTH-1]);
            end
            OP_AND: alu_res = rs_ & opb;
            OP_OR:  alu_res = rs_ | opb;
            OP_XOR: alu_res = rs_ ^ opb;
            OP_NOR: alu_res = ~(rs_ | opb);
            OP_SLL: begin
                alu_res = sll_x[WIDTH-1:0];
                alu_c   = sll_x[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_x[WIDTH:1];
                alu_c   = srl_x[0];
            end
            OP_SRA: begin
                alu_res = sra_x[WIDTH:1];
                alu_c   = sra_x[0];
            end
            // Undefined ops (and MUL, which never takes this path when the
            // multiplier is built) produce all-zero result and flags.
            default: alu_known = 1'b0;
        endcase
        // zFlag must stay 0 for undefined ops even though the result is 0
        alu_z = alu_known && (alu_res == '0);
        alu_s = alu_res[WIDTH-1];
    end

`ifdef SEQ_ALU_MUL_EN
    // ------------------------------------------------------------------------
    // Iterative shift-add multiplier
    // ------------------------------------------------------------------------
    localparam logic [3:0]     OP_MUL   = 4'd9;
    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_MUL    = 1'b1;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [0:0]         state;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   mcand;
    // acc[WIDTH-1:0] starts as the multiplier and is consumed LSB-first while
    // the product grows in from the top; after WIDTH steps acc is the product.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] acc_next;

    assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_next = {partial, acc[WIDTH-1:1]};
    assign busy     = (state == S_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mcand        <= '0;
            acc          <= '0;
            result       <= '0;
            resultHi     <= '0;
            zFlag        <= 1'b0;
            carryFlag    <= 1'b0;
            signFlag     <= 1'b0;
            overflowFlag <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand <= rs_;
                            acc   <= {{WIDTH{1'b0}}, opb};
                            cnt   <= '0;
                            state <= S_MUL;
                        end else begin
                            result       <= alu_res;
                            resultHi     <= '0;
                            zFlag        <= alu_z;
                            carryFlag    <= alu_c;
                            signFlag     <= alu_s;
                            overflowFlag <= alu_v;
                            done         <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // start is not looked at here: requests while busy are dropped
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result       <= acc_next[WIDTH-1:0];
                        resultHi     <= acc_next[2*WIDTH-1:WIDTH];
                        zFlag        <= (acc_next[WIDTH-1:0] == '0);
                        carryFlag    <= 1'b0;
                        signFlag     <= acc_next[WIDTH-1];
                        overflowFlag <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                        done         <= 1'b1;
                        cnt          <= '0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    // ------------------------------------------------------------------------
    // No multiplier: every accepted request completes on the next edge
    // ------------------------------------------------------------------------
    assign busy     = 1'b0;
    assign resultHi = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            zFlag        <= 1'b0;
            carryFlag    <= 1'b0;
            signFlag     <= 1'b0;
            overflowFlag <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                result       <= alu_res;
                zFlag        <= alu_z;
                carryFlag    <= alu_c;
                signFlag     <= alu_s;
                overflowFlag <= alu_v;
                done         <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu -- directed, scoreboarded bench for seq_alu (WIDTH = 32)
//   Expected completions are queued when a request is issued and popped when
//   done is observed. Outputs are sampled on the falling edge.
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] rs_;
    logic [W-1:0] rt_;
    logic [W-1:0] imm;
    logic         ALUimm;
    logic [W-1:0] result;
    logic [W-1:0] resultHi;
    logic         zFlag;
    logic         carryFlag;
    logic         signFlag;
    logic         overflowFlag;
    logic         busy;
    logic         done;

    seq_alu #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .rs_          (rs_),
        .rt_          (rt_),
        .imm          (imm),
        .ALUimm       (ALUimm),
        .result       (result),
        .resultHi     (resultHi),
        .zFlag        (zFlag),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         s;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk32({tag, ".result"},   result,   32'h0);
        chk32({tag, ".resultHi"}, resultHi, 32'h0);
        chk1({tag, ".z"},    zFlag,        1'b0);
        chk1({tag, ".c"},    carryFlag,    1'b0);
        chk1({tag, ".s"},    signFlag,     1'b0);
        chk1({tag, ".v"},    overflowFlag, 1'b0);
        chk1({tag, ".busy"}, busy,         1'b0);
        chk1({tag, ".done"}, done,         1'b0);
    endtask

    // Drive a request at the current (falling) edge and queue its expectation.
    task automatic issue(input string tag, input logic [3:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic use_imm,
                         input logic [W-1:0] er, input logic [W-1:0] eh,
                         input logic ez, input logic ec, input logic es, input logic ev);
        exp_t e;
        op     = o;
        rs_    = a;
        ALUimm = use_imm;
        if (use_imm) begin imm = b; rt_ = ~b; end
        else         begin rt_ = b; imm = ~b; end
        start  = 1'b1;
        e = '{tag, er, eh, ez, ec, es, ev};
        sb.push_back(e);
    endtask

    // Drop start, scramble inputs, wait for done (bounded) and score it.
    // exp_wait = edges after the accepting edge until done (0 single, W for MUL),
    // which is also the number of sampled cycles busy must be high.
    task automatic collect(input int exp_wait, input bit poke);
        exp_t e;
        int j    = 0;
        int bcnt = 0;
        @(negedge clk);
        start  = 1'b0;
        rs_    = $urandom;
        rt_    = $urandom;
        imm    = $urandom;
        ALUimm = 1'($urandom);
        op     = 4'($urandom);
        while (!done && j < 200) begin
            if (busy) bcnt++;
            if (poke && j == 5) begin
                start = 1'b1; op = OP_ADD; rs_ = 32'd1; rt_ = 32'd1; ALUimm = 1'b0;
            end
            if (poke && j == 6) start = 1'b0;
            @(negedge clk);
            j++;
        end
        chk1("done_seen", done, 1'b1);
        chk32("latency", 32'(j), 32'(exp_wait));
        chk32("busy_cycles", 32'(bcnt), 32'(exp_wait));
        chk1("busy_at_done", busy, 1'b0);
        chk32("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk32({e.tag, ".result"},   result,   e.res);
            chk32({e.tag, ".resultHi"}, resultHi, e.hi);
            chk1({e.tag, ".z"}, zFlag,        e.z);
            chk1({e.tag, ".c"}, carryFlag,    e.c);
            chk1({e.tag, ".s"}, signFlag,     e.s);
            chk1({e.tag, ".v"}, overflowFlag, e.v);
        end
    endtask

    // Quiet cycles: done must not pulse again and nothing may be in flight.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk1("idle_done_low", done, 1'b0);
            chk1("idle_busy_low", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = '0;
        rs_    = '0;
        rt_    = '0;
        imm    = '0;
        ALUimm = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;

        // add / sub
        issue("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 32'h0, 0, 0, 1, 1);
        collect(0, 0);
        issue("sub_eq",  OP_SUB, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0);
        collect(0, 0);
        issue("sub_neg", OP_SUB, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 0, 1, 0);
        collect(0, 0);
        issue("add_cy",  OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0);
        collect(0, 0);
        issue("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 32'h0, 0, 1, 0, 1);
        collect(0, 0);
        idle(2);

        // logic
        issue("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 32'h0, 0, 0, 1, 0);
        collect(0, 0);
        issue("or",  OP_OR,  32'h0F0F0000, 32'h000000F0, 1'b1, 32'h0F0F00F0, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        issue("xor", OP_XOR, 32'hAAAA5555, 32'hAAAA5555, 1'b0, 32'h0, 32'h0, 1, 0, 0, 0);
        collect(0, 0);
        issue("nor", OP_NOR, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h0, 0, 0, 1, 0);
        collect(0, 0);

        // shifts
        issue("sra1",   OP_SRA, 32'h80000001, 32'h21, 1'b0, 32'hC0000000, 32'h0, 0, 1, 1, 0);
        collect(0, 0);
        issue("sll0",   OP_SLL, 32'h12345678, 32'h20, 1'b0, 32'h12345678, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        issue("srl4",   OP_SRL, 32'h8000000F, 32'h4, 1'b1, 32'h08000000, 32'h0, 0, 1, 0, 0);
        collect(0, 0);
        issue("sll1",   OP_SLL, 32'h80000001, 32'h1, 1'b0, 32'h00000002, 32'h0, 0, 1, 0, 0);
        collect(0, 0);
        issue("sll31",  OP_SLL, 32'h3, 32'h1F, 1'b1, 32'h80000000, 32'h0, 0, 1, 1, 0);
        collect(0, 0);
        issue("sra31",  OP_SRA, 32'h7FFFFFFF, 32'h1F, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0);
        collect(0, 0);
        idle(2);

        // undefined op after a nonzero result
        issue("pre_undef", OP_ADD, 32'h100, 32'h23, 1'b0, 32'h123, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        issue("op15", 4'd15, 32'hDEAD, 32'hBEEF, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        idle(1);

`ifdef SEQ_ALU_MUL_EN
        // multiply, with a start poked mid-iteration that must be dropped
        issue("mul_big", OP_MUL, 32'hFFFFFFFF, 32'h2, 1'b0, 32'hFFFFFFFE, 32'h1, 0, 0, 1, 1);
        collect(W, 1);
        // issued in the done cycle: back-to-back, also clears resultHi
        issue("b2b_add", OP_ADD, 32'd10, 32'd20, 1'b1, 32'd30, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        issue("mul_small", OP_MUL, 32'd3, 32'd5, 1'b1, 32'd15, 32'h0, 0, 0, 0, 0);
        collect(W, 0);
        issue("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 1);
        collect(W, 0);

        // reset 10 cycles into a MUL: abort without done
        issue("mul_abort", OP_MUL, 32'd7, 32'd9, 1'b0, 32'd63, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk1("abort_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk_zero_outputs("abort_reset");
        void'(sb.pop_front());
        reset = 1'b0;
        idle(W + 2);
`else
        issue("op9", OP_MUL, 32'hFFFFFFFF, 32'h2, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        issue("pre_reset", OP_OR, 32'hA5, 32'h5A00, 1'b0, 32'h5AA5, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_zero_outputs("mid_reset");
        reset = 1'b0;
        idle(2);
`endif
        issue("post_reset_add", OP_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 32'h0, 0, 0, 0, 0);
        collect(0, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath's single-cycle 32-bit ALU. Supports add/sub, four logic ops, three shifts and an optional iterative unsigned multiply, with a start/done handshake so the execute stage can stall on long operations. Operand selection (register vs. immediate) is internal. Result and flags are registered and held until the next completion.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10–15 undefined
- rs_  in  WIDTH  operand A
- rt_  in  WIDTH  operand B (register)
- imm  in  WIDTH  operand B (immediate, pre-extended by decode)
- ALUimm  in  1  1: B = imm, 0: B = rt_
- result  out  WIDTH  registered result (low word for MUL)
- resultHi  out  WIDTH  MUL high word; 0 for all other ops
- zFlag, carryFlag, signFlag, overflowFlag  out  1 each  registered flags
- busy  out  1  high while a MUL is iterating
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, MUL. Operands A, B and op captured on the edge that accepts start.
- IDLE & start & op≠MUL: compute combinationally from captured inputs, register result/flags, done=1 next cycle, stay IDLE.
- IDLE & start & op=MUL: load multiplicand, multiplier, 2·WIDTH accumulator, counter=0; go MUL.
- MUL: one shift-add step per cycle (add multiplicand if multiplier LSB=1, shift right); counter increments; at counter=WIDTH−1 write {resultHi,result}, pulse done, return IDLE.
- start while busy is ignored (not queued).
- ADD/SUB: A + B / A + ~B + 1 over WIDTH bits. carryFlag = carry-out of bit WIDTH−1 (SUB: 1 = no borrow). overflowFlag = signed overflow. signFlag = result[WIDTH−1]. zFlag = (result==0).
- AND/OR/XOR/NOR: bitwise; carryFlag=overflowFlag=0; z/sign from result.
- SLL/SRL/SRA: shift A by B[SHW−1:0]; upper bits of B ignored; carryFlag = last bit shifted out (0 if amount 0); overflowFlag=0.
- MUL: unsigned WIDTH×WIDTH→2·WIDTH. z/sign from low word; carryFlag=0; overflowFlag = (resultHi≠0).
- Undefined op: result=0, resultHi=0, all flags 0, done still pulses after 1 cycle.
- resultHi cleared to 0 on every non-MUL completion.

## Timing
- Reset: state IDLE, result=0, resultHi=0, all flags 0, busy=0, done=0, counter=0.
- Single-cycle ops: start sampled at edge N → result/flags/done valid in cycle after N; latency 1.
- MUL: start at edge N → busy=1 cycles N+1..N+WIDTH; result, flags, done=1 valid after edge N+WIDTH, busy=0 in same cycle; latency WIDTH.
- done is exactly one cycle wide; new start accepted in the done cycle (back-to-back, no bubble).
- Outputs hold last completed value until next completion; input changes after capture have no effect.
- reset during MUL: abort immediately, no done pulse, outputs go to reset values.

## Configuration
- SEQ_ALU_MUL_EN defined: MUL state, counter, accumulator and resultHi logic compiled in as above.
- Not defined: no MUL state or datapath; op=9 treated as undefined (1-cycle, result 0, flags 0); busy and resultHi tied 0.

## Test plan
- Reset then WIDTH=32 ADD rs_=0x7FFFFFFF, rt_=1, ALUimm=0 → result 0x80000000, sign=1, overflow=1, carry=0, z=0, done one cycle after start.
- SUB rs_=5, imm=5, ALUimm=1 → result 0, z=1, carry=1 (no borrow), overflow=0; SUB 3−5 → 0xFFFFFFFE, carry=0, sign=1.
- SRA rs_=0x80000001, rt_=0x21 (amount 1) → result 0xC0000000, carry=1; SLL by 0 → result=rs_, carry=0.
- MUL (macro on) 0xFFFFFFFF×2 → busy 32 cycles, done at cycle 32, resultHi=1, result=0xFFFFFFFE, overflow=1; start during busy ignored; back-to-back ADD on done cycle completes next cycle.
- reset asserted at MUL cycle 10 → no done, all outputs 0, next ADD 1+1 → 2 after 1 cycle.
- Macro off: op=9 and op=15 → result 0, flags 0, busy never asserts, done after 1 cycle.
